// File: rtl/mem_1rw_ctrl_pkg.sv
// Shared types and helpers for the 1rw byte-mask SRAM controller.
package mem_1rw_ctrl_pkg;

  // Controller phase: zero-fill sweep after reset, then request service.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to index n entries; never returns 0 so depth-1 structures stay legal.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_1rw_ctrl_resp_fifo.sv
// Read-response buffer: els_p-deep, width_p-wide FIFO with occupancy count.
// Storage is not reset; only pointers and count are, which is enough to
// make every buffered entry invisible after reset.
module mem_1rw_ctrl_resp_fifo
  import mem_1rw_ctrl_pkg::*;
#(
  parameter int width_p = 64,
  parameter int els_p   = 3,
  localparam int ptr_w_lp = ptr_width(els_p),
  localparam int cnt_w_lp = ptr_width(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                enq_i,
  input  logic [width_p-1:0]  data_i,
  input  logic                deq_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q;
  logic [ptr_w_lp-1:0] rd_ptr_q;
  logic [cnt_w_lp-1:0] count_q;
  logic                deq_eff;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign v_o     = (count_q != '0);
  assign deq_eff = deq_i & v_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Entry storage; written on every enqueue, including when full with a dequeue.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy update; enqueue and dequeue together leave the count unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq_i)   wr_ptr_q <= bump(wr_ptr_q);
      if (deq_eff) rd_ptr_q <= bump(rd_ptr_q);
      case ({enq_i, deq_eff})
        2'b10:   count_q <= count_q + cnt_w_lp'(1);
        2'b01:   count_q <= count_q - cnt_w_lp'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_1rw_byte_mask_ctrl.sv
// Controller for a single-port (1rw) byte-mask SRAM: zero-fills the array after
// reset, then issues requests straight to the SRAM and buffers read data in order.
//
// Handshakes:
//   request  - a transfer happens in a cycle where req_v_i and req_ready_o are both 1;
//              req_ready_o depends only on registered state, never on req_v_i or resp_yumi_i.
//   response - resp_v_o offers the oldest buffered read; the consumer takes it by raising
//              resp_yumi_i, which is only legal while resp_v_o is 1.
module mem_1rw_byte_mask_ctrl
  import mem_1rw_ctrl_pkg::*;
#(
  parameter int width_p    = 64,
  parameter int els_p      = 512,
  parameter int resp_els_p = 3,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [addr_width_lp-1:0] req_addr_i,
  input  logic [width_p-1:0]       req_data_i,
  input  logic [mask_width_lp-1:0] req_mask_i,
  output logic                     resp_v_o,
  output logic [width_p-1:0]       resp_data_o,
  input  logic                     resp_yumi_i,
  output logic                     init_done_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [mask_width_lp-1:0] mem_mask_o,
  input  logic [width_p-1:0]       mem_data_i,
  output state_e                   state_o
);

  localparam int cnt_w_lp = ptr_width(resp_els_p + 1);
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  state_e                   state_q;
  state_e                   state_n;
  logic [addr_width_lp-1:0] sweep_q;
  logic                     rd_inflight_q;
  logic [cnt_w_lp-1:0]      resp_count;
  logic [cnt_w_lp:0]        credit_used;
  logic                     accept;

  // Credit covers both buffered responses and the read whose SRAM data lands next cycle,
  // so a capture can never find the buffer full without a simultaneous dequeue.
  assign credit_used = {1'b0, resp_count} + (cnt_w_lp + 1)'(rd_inflight_q);
  assign req_ready_o = (state_q == RUN) && (credit_used < (cnt_w_lp + 1)'(resp_els_p));
  assign accept      = req_v_i & req_ready_o;
  assign init_done_o = (state_q == RUN);
  assign state_o     = state_q;

  // Phase register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= INIT;
    else            state_q <= state_n;
  end

  // Leave the sweep once the last word has been written.
  always_comb begin
    state_n = state_q;
    if ((state_q == INIT) && (sweep_q == last_addr_lp)) state_n = RUN;
  end

  // Zero-fill address counter, advancing one word per cycle during INIT.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            sweep_q <= '0;
    else if (state_q == INIT)  sweep_q <= sweep_q + addr_width_lp'(1);
  end

  // Marks that SRAM read data is due on mem_data_i in the coming cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rd_inflight_q <= 1'b0;
    else            rd_inflight_q <= accept & ~req_w_i;
  end

  // SRAM port: sweep writes during INIT, combinational pass-through of accepted requests in RUN.
  // Gating with reset_n_i keeps the port idle while reset is held.
  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_mask_o = '0;
    if (state_q == INIT) begin
      mem_v_o    = reset_n_i;
      mem_w_o    = 1'b1;
      mem_addr_o = sweep_q;
      mem_mask_o = '1;
    end else if (accept) begin
      mem_v_o    = 1'b1;
      mem_w_o    = req_w_i;
      mem_addr_o = req_addr_i;
      mem_data_o = req_data_i;
      mem_mask_o = req_mask_i;
    end
  end

  mem_1rw_ctrl_resp_fifo #(
    .width_p (width_p),
    .els_p   (resp_els_p)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (rd_inflight_q),
    .data_i    (mem_data_i),
    .deq_i     (resp_yumi_i),
    .v_o       (resp_v_o),
    .data_o    (resp_data_o),
    .count_o   (resp_count)
  );

endmodule

// File: tb/tb_mem_1rw_byte_mask_ctrl.sv
// Bench for mem_1rw_byte_mask_ctrl with a 16-word SRAM model.
module tb_mem_1rw_byte_mask_ctrl;
  import mem_1rw_ctrl_pkg::*;

  localparam int W    = 64;
  localparam int ELS  = 16;
  localparam int RESP = 3;
  localparam int AW   = 4;
  localparam int MW   = 8;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          req_v, req_w, req_ready;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_data;
  logic [MW-1:0] req_mask;
  logic          resp_v, resp_yumi, yumi_en, yumi_rand;
  logic [W-1:0]  resp_data;
  logic          init_done;
  logic          mem_v, mem_w;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic [MW-1:0] mem_mask;
  state_e        state;

  assign resp_yumi = yumi_en & resp_v;

  mem_1rw_byte_mask_ctrl #(.width_p(W), .els_p(ELS), .resp_els_p(RESP)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .req_v_i     (req_v),
    .req_ready_o (req_ready),
    .req_w_i     (req_w),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_mask_i  (req_mask),
    .resp_v_o    (resp_v),
    .resp_data_o (resp_data),
    .resp_yumi_i (resp_yumi),
    .init_done_o (init_done),
    .mem_v_o     (mem_v),
    .mem_w_o     (mem_w),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_mask_o  (mem_mask),
    .mem_data_i  (mem_rdata),
    .state_o     (state)
  );

  // SRAM model: byte-masked write, read data one cycle later, garbage otherwise.
  logic [W-1:0] sram [ELS];
  always @(posedge clk) begin
    if (mem_v && mem_w)
      for (int b = 0; b < MW; b++)
        if (mem_mask[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_v && !mem_w) mem_rdata <= sram[mem_addr];
    else                 mem_rdata <= {$urandom, $urandom};
  end

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] ref_mem [ELS];
  logic [W-1:0] exp_q[$];
  int           age_q[$];
  logic [W-1:0] got_q[$];
  int checks   = 0;
  int failures = 0;
  int mon_cyc  = 0;
  int rel_cyc  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [MW-1:0] m);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Cycles since reset release; cycle k of the sweep writes word k.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rel_cyc <= 0;
    else          rel_cyc <= rel_cyc + 1;
  end

  // Monitor: checks every cycle between edges while out of reset.
  always @(negedge clk) begin : monitor
    logic acc;
    logic run;
    acc = 1'b0;
    mon_cyc++;
    if (reset_n) begin
      run = (rel_cyc >= ELS);
      check("init_done", init_done, run);
      check("state_run", state == RUN, run);
      check("req_ready", req_ready, run && (exp_q.size() < RESP));
      if (!run) begin
        check("sweep_v", mem_v, 1);
        check("sweep_w", mem_w, 1);
        check("sweep_addr", mem_addr, rel_cyc);
        check("sweep_mask", mem_mask, 8'hFF);
        check("sweep_data", mem_wdata, 0);
      end else begin
        acc = req_v && req_ready;
        check("mem_v", mem_v, acc);
        if (acc) begin
          check("mem_w", mem_w, req_w);
          check("mem_addr", mem_addr, req_addr);
          check("mem_data", mem_wdata, req_data);
          check("mem_mask", mem_mask, req_mask);
        end
      end
      if (resp_v) begin
        check("resp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("resp_latency", mon_cyc >= age_q[0] + 2, 1);
          check("resp_data", resp_data, exp_q[0]);
          if (resp_yumi) begin
            got_q.push_back(resp_data);
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
          end
        end
      end
      if (acc) begin
        if (req_w) ref_mem[req_addr] = merge(ref_mem[req_addr], req_data, req_mask);
        else begin
          exp_q.push_back(ref_mem[req_addr]);
          age_q.push_back(mon_cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic tick_rv;

  task automatic tick(output logic acc);
    @(negedge clk);
    acc     = req_v && req_ready;
    tick_rv = resp_v;
    @(posedge clk);
    #1;
    if (yumi_rand) yumi_en = 1'($urandom_range(0, 1));
  endtask

  task automatic do_op(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [MW-1:0] m, output int n);
    logic acc;
    acc = 1'b0;
    n = 0;
    req_v = 1'b1; req_w = w; req_addr = a; req_data = d; req_mask = m;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    check("op_accept", acc, 1);
    req_v = 1'b0;
  endtask

  task automatic drain();
    logic dummy;
    int n;
    n = 0;
    yumi_en = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      tick(dummy);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_v   = 1'b0;
    yumi_en = 1'b0;
    #1;
    check("rst_resp_v", resp_v, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_mem_v", mem_v, 0);
    exp_q.delete();
    age_q.delete();
    got_q.delete();
    for (int i = 0; i < ELS; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [MW-1:0] mask;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t tab[9];

  // ---------------- test sequence ----------------
  initial begin : main
    logic [W-1:0] tab_exp[$];
    logic acc;
    logic rv[8];
    int n, accepts;

    tab[0] = '{1'b0, 4'd5,  64'h0,                  8'h00, 64'h0};
    tab[1] = '{1'b1, 4'd3,  64'h1122334455667788,   8'hFF, 64'h0};
    tab[2] = '{1'b1, 4'd3,  64'hAAAAAAAAAAAAAAAA,   8'h0F, 64'h0};
    tab[3] = '{1'b0, 4'd3,  64'h0,                  8'h00, 64'h11223344AAAAAAAA};
    tab[4] = '{1'b1, 4'd9,  64'hDEADBEEFCAFEF00D,   8'hA5, 64'h0};
    tab[5] = '{1'b0, 4'd9,  64'h0,                  8'h00, 64'hDE00BE0000FE000D};
    tab[6] = '{1'b1, 4'd3,  64'h5555555555555555,   8'h80, 64'h0};
    tab[7] = '{1'b0, 4'd3,  64'h0,                  8'h00, 64'h55223344AAAAAAAA};
    tab[8] = '{1'b0, 4'd12, 64'h0,                  8'h00, 64'h0};

    for (int i = 0; i < ELS; i++) sram[i] = {$urandom, $urandom};
    req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
    yumi_en = 1'b0; yumi_rand = 1'b0;
    reset_n = 1'b1;
    #2;
    apply_reset();

    // Zero-fill sweep: cycles 0..15, then RUN from cycle 16.
    repeat (ELS) tick(acc);

    // Table: reads checked in order against hand-computed results.
    yumi_en = 1'b1;
    got_q.delete();
    for (int i = 0; i < 9; i++) begin
      do_op(tab[i].w, tab[i].addr, tab[i].data, tab[i].mask, n);
      if (!tab[i].w) tab_exp.push_back(tab[i].exp);
    end
    drain();
    check("tab_count", got_q.size(), tab_exp.size());
    for (int i = 0; i < tab_exp.size(); i++) check("tab_read", got_q[i], tab_exp[i]);

    // Credit limit with the consumer stalled, then one dequeue frees one slot.
    yumi_en = 1'b0;
    req_v = 1'b1; req_w = 1'b0; req_addr = 4'd7;
    accepts = 0;
    repeat (8) begin tick(acc); accepts += int'(acc); end
    check("credit_accepts", accepts, 3);
    check("credit_ready_low", req_ready, 0);
    yumi_en = 1'b1;
    accepts = 0;
    tick(acc); accepts += int'(acc);
    yumi_en = 1'b0;
    repeat (6) begin tick(acc); accepts += int'(acc); end
    check("credit_one_more", accepts, 1);
    req_v = 1'b0;
    drain();

    // Back-to-back reads at full rate with the consumer always ready.
    for (int i = 0; i < 8; i++) do_op(1'b1, 4'(i), 64'(i), 8'hFF, n);
    got_q.delete();
    yumi_en = 1'b1;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      req_v = 1'b1; req_w = 1'b0; req_addr = 4'(i);
      tick(acc);
      accepts += int'(acc);
      rv[i] = tick_rv;
    end
    req_v = 1'b0;
    check("b2b_accepts", accepts, 8);
    check("b2b_first_resp_n1", rv[1], 0);
    check("b2b_first_resp_n2", rv[2], 1);
    drain();
    check("b2b_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) check("b2b_order", got_q[i], 64'(i));

    // Random traffic with a randomly stalling consumer.
    yumi_rand = 1'b1;
    repeat (250) begin
      if ($urandom_range(0, 3) == 0) begin
        req_v = 1'b0;
        tick(acc);
      end else begin
        do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, ELS - 1)),
              {$urandom, $urandom}, 8'($urandom_range(0, 255)), n);
      end
    end
    yumi_rand = 1'b0;
    drain();

    // Reset with two reads outstanding: everything discarded, sweep restarts.
    yumi_en = 1'b0;
    do_op(1'b0, 4'd3, '0, '0, n);
    do_op(1'b0, 4'd9, '0, '0, n);
    check("pre_reset_resp_v", resp_v, 1);
    apply_reset();
    repeat (ELS + 4) tick(acc);
    yumi_en = 1'b1;
    got_q.delete();
    do_op(1'b0, 4'd3, '0, '0, n);
    drain();
    check("post_reset_count", got_q.size(), 1);
    check("post_reset_zero", got_q[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
